cv32e40p_tmr_vote_monitor: RTL and testbench

Registered triple-modular-redundancy voter with fault bookkeeping. It replaces the purely combinational 3-way voter wherever a replicated word is consumed, such as register-file read ports and pipeline-stage outputs. It tracks consecutive disagreements per replica and masks a replica that is persistently faulty, degrading from TRIPLE to DUAL mode. It then drops to a sticky FAIL mode when the two surviving replicas disagree. Intended for the cv32e40p fault-tolerant datapath.

---
 rtl/cv32e40p_tmr_vote_monitor.sv | 153 +++++++++++++++
 tb/tb_cv32e40p_tmr_vote_monitor.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/cv32e40p_tmr_vote_monitor.sv
// Registered triple-modular-redundancy voter that counts consecutive minority events per replica,
// masks a persistently faulty replica (TRIPLE -> DUAL) and latches a sticky FAIL on a dual divergence.
module cv32e40p_tmr_vote_monitor #(
    parameter int unsigned LEN       = 32,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned THRESHOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_i,
    input  logic [LEN-1:0]       in_1_i,
    input  logic [LEN-1:0]       in_2_i,
    input  logic [LEN-1:0]       in_3_i,
    input  logic                 clear_i,
    output logic [LEN-1:0]       voted_o,
    output logic                 valid_o,
    output logic [2:0]           err_detected_o,
    output logic                 err_corrected_o,
    output logic                 err_uncorrectable_o,
    output logic [1:0]           mode_o,
    output logic [2:0]           masked_o,
    output logic [3*CNT_W-1:0]   err_cnt_o
);

    typedef enum logic [1:0] {
        TRIPLE = 2'b00,
        DUAL   = 2'b01,
        FAIL   = 2'b10
    } mode_e;

    if (THRESHOLD < 1 || THRESHOLD > (1 << CNT_W) - 1) begin : g_bad_threshold
        $error("THRESHOLD must be in 1 .. 2**CNT_W-1");
    end

    mode_e                  mode_q;
    logic [2:0]             masked_q;
    logic [2:0][CNT_W-1:0]  cnt_q;

    logic           eq12, eq13, eq23;
    logic [LEN-1:0] t_vote;
    logic [2:0]     t_det;
    logic [2:0]     t_min;
    logic           t_corr, t_unc;
    logic [LEN-1:0] lo_word, hi_word;
    logic [2:0]     lo_bit, hi_bit;
    logic           d_eq;

    assign eq12 = (in_1_i == in_2_i);
    assign eq13 = (in_1_i == in_3_i);
    assign eq23 = (in_2_i == in_3_i);

    always_comb begin
        t_vote = in_1_i;
        t_det  = '0;
        t_min  = '0;
        t_corr = 1'b0;
        t_unc  = 1'b0;
        if (eq12 && eq13) begin
            t_vote = in_1_i;
        end else if (eq12) begin
            t_det  = 3'b100;
            t_min  = 3'b100;
            t_corr = 1'b1;
        end else if (eq13) begin
            t_det  = 3'b010;
            t_min  = 3'b010;
            t_corr = 1'b1;
        end else if (eq23) begin
            t_vote = in_2_i;
            t_det  = 3'b001;
            t_min  = 3'b001;
            t_corr = 1'b1;
        end else begin
            t_det  = 3'b111;
            t_unc  = 1'b1;
        end
    end

    // Survivors in DUAL/FAIL: lowest and highest unmasked replica (masked_q is one-hot there).
    assign lo_word = masked_q[0] ? in_2_i : in_1_i;
    assign hi_word = masked_q[2] ? in_2_i : in_3_i;
    assign lo_bit  = masked_q[0] ? 3'b010 : 3'b001;
    assign hi_bit  = masked_q[2] ? 3'b010 : 3'b100;
    assign d_eq    = (lo_word == hi_word);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            voted_o             <= '0;
            valid_o             <= 1'b0;
            err_detected_o      <= '0;
            err_corrected_o     <= 1'b0;
            err_uncorrectable_o <= 1'b0;
            mode_q              <= TRIPLE;
            masked_q            <= '0;
            cnt_q               <= '0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                if (clear_i || mode_q == TRIPLE) begin
                    voted_o             <= t_vote;
                    err_detected_o      <= t_det;
                    err_corrected_o     <= t_corr;
                    err_uncorrectable_o <= t_unc;
                end else if (mode_q == DUAL) begin
                    voted_o             <= lo_word;
                    err_detected_o      <= d_eq ? 3'b000 : (lo_bit | hi_bit);
                    err_corrected_o     <= 1'b0;
                    err_uncorrectable_o <= !d_eq;
                end else begin
                    voted_o             <= lo_word;
                    err_detected_o      <= '0;
                    err_corrected_o     <= 1'b0;
                    err_uncorrectable_o <= 1'b1;
                end
            end

            if (clear_i) begin
                mode_q   <= TRIPLE;
                masked_q <= '0;
                cnt_q    <= '0;
            end else if (valid_i) begin
                case (mode_q)
                    TRIPLE: begin
                        for (int unsigned i = 0; i < 3; i++) begin
                            if (t_min[i]) begin
                                if (cnt_q[i] != '1) begin
                                    cnt_q[i] <= cnt_q[i] + 1'b1;
                                end
                                if (cnt_q[i] == CNT_W'(THRESHOLD - 1)) begin
                                    masked_q[i] <= 1'b1;
                                    mode_q      <= DUAL;
                                end
                            end else if (!t_unc) begin
                                cnt_q[i] <= '0;
                            end
                        end
                    end
                    DUAL: begin
                        if (!d_eq) begin
                            mode_q <= FAIL;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mode_o    = mode_q;
    assign masked_o  = masked_q;
    assign err_cnt_o = cnt_q;

endmodule

// File: tb/tb_cv32e40p_tmr_vote_monitor.sv
// Directed-vector bench for cv32e40p_tmr_vote_monitor with hand-computed expectations.
module tb_cv32e40p_tmr_vote_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid_i = 1'b0;
    logic [31:0] in_1_i = '0;
    logic [31:0] in_2_i = '0;
    logic [31:0] in_3_i = '0;
    logic        clear_i = 1'b0;
    logic [31:0] voted_o;
    logic        valid_o;
    logic [2:0]  err_detected_o;
    logic        err_corrected_o;
    logic        err_uncorrectable_o;
    logic [1:0]  mode_o;
    logic [2:0]  masked_o;
    logic [11:0] err_cnt_o;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    cv32e40p_tmr_vote_monitor #(
        .LEN(32),
        .CNT_W(4),
        .THRESHOLD(4)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .valid_i             (valid_i),
        .in_1_i              (in_1_i),
        .in_2_i              (in_2_i),
        .in_3_i              (in_3_i),
        .clear_i             (clear_i),
        .voted_o             (voted_o),
        .valid_o             (valid_o),
        .err_detected_o      (err_detected_o),
        .err_corrected_o     (err_corrected_o),
        .err_uncorrectable_o (err_uncorrectable_o),
        .mode_o              (mode_o),
        .masked_o            (masked_o),
        .err_cnt_o           (err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the capturing edge.
    task automatic apply(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic clr);
        valid_i = v;
        in_1_i  = a;
        in_2_i  = b;
        in_3_i  = c;
        clear_i = clr;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        clear_i = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [31:0] vote, input logic [2:0] det,
                             input logic corr, input logic unc, input logic [1:0] mode,
                             input logic [2:0] msk, input logic [11:0] cnt);
        check({tag, ".voted"}, 64'(voted_o), 64'(vote));
        check({tag, ".det"},   64'(err_detected_o), 64'(det));
        check({tag, ".corr"},  64'(err_corrected_o), 64'(corr));
        check({tag, ".unc"},   64'(err_uncorrectable_o), 64'(unc));
        check({tag, ".mode"},  64'(mode_o), 64'(mode));
        check({tag, ".mask"},  64'(masked_o), 64'(msk));
        check({tag, ".cnt"},   64'(err_cnt_o), 64'(cnt));
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst.valid", 64'(valid_o), 64'd0);
        check_all("rst", 32'h0, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000, 12'h000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        apply(1'b1, 32'hA5A5_0001, 32'hA5A5_0001, 32'hA5A5_0001, 1'b0);
        check("agree.valid", 64'(valid_o), 64'd1);
        check_all("agree", 32'hA5A5_0001, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000, 12'h000);

        apply(1'b1, 32'h1234_5678, 32'h0000_FFFF, 32'h1234_5678, 1'b0);
        check_all("r2f1", 32'h1234_5678, 3'b010, 1'b1, 1'b0, 2'b00, 3'b000, 12'h010);
        apply(1'b1, 32'h1234_5678, 32'h0000_FFFF, 32'h1234_5678, 1'b0);
        check_all("r2f2", 32'h1234_5678, 3'b010, 1'b1, 1'b0, 2'b00, 3'b000, 12'h020);
        apply(1'b1, 32'h1234_5678, 32'h0000_FFFF, 32'h1234_5678, 1'b0);
        check_all("r2f3", 32'h1234_5678, 3'b010, 1'b1, 1'b0, 2'b00, 3'b000, 12'h030);
        apply(1'b1, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 1'b0);
        check_all("r2ok", 32'h1234_5678, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000, 12'h000);

        // Idle cycle: valid_o drops, everything else holds.
        apply(1'b0, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
        check("idle.valid", 64'(valid_o), 64'd0);
        check_all("idle", 32'h1234_5678, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000, 12'h000);

        apply(1'b1, 32'h5, 32'h7, 32'h7, 1'b0);
        check_all("r1f", 32'h7, 3'b001, 1'b1, 1'b0, 2'b00, 3'b000, 12'h001);
        apply(1'b1, 32'h1, 32'h2, 32'h3, 1'b0);
        check_all("alldiff", 32'h1, 3'b111, 1'b0, 1'b1, 2'b00, 3'b000, 12'h001);

        apply(1'b1, 32'hCAFE_0000, 32'hCAFE_0000, 32'hDEAD_0000, 1'b0);
        check_all("r3f1", 32'hCAFE_0000, 3'b100, 1'b1, 1'b0, 2'b00, 3'b000, 12'h100);
        apply(1'b1, 32'hCAFE_0000, 32'hCAFE_0000, 32'hDEAD_0000, 1'b0);
        check_all("r3f2", 32'hCAFE_0000, 3'b100, 1'b1, 1'b0, 2'b00, 3'b000, 12'h200);
        apply(1'b1, 32'hCAFE_0000, 32'hCAFE_0000, 32'hDEAD_0000, 1'b0);
        check_all("r3f3", 32'hCAFE_0000, 3'b100, 1'b1, 1'b0, 2'b00, 3'b000, 12'h300);
        apply(1'b1, 32'hCAFE_0000, 32'hCAFE_0000, 32'hDEAD_0000, 1'b0);
        check_all("r3mask", 32'hCAFE_0000, 3'b100, 1'b1, 1'b0, 2'b01, 3'b100, 12'h400);

        apply(1'b1, 32'h55, 32'h55, 32'h99, 1'b0);
        check_all("dualeq", 32'h55, 3'b000, 1'b0, 1'b0, 2'b01, 3'b100, 12'h400);
        apply(1'b1, 32'h1, 32'h2, 32'h2, 1'b0);
        check_all("dualdiv", 32'h1, 3'b011, 1'b0, 1'b1, 2'b10, 3'b100, 12'h400);
        apply(1'b1, 32'h77, 32'h77, 32'h77, 1'b0);
        check("fail.voted", 64'(voted_o), 64'h77);
        check("fail.unc", 64'(err_uncorrectable_o), 64'd1);
        check("fail.mode", 64'(mode_o), 64'd2);
        check("fail.cnt", 64'(err_cnt_o), 64'h400);

        apply(1'b1, 32'h9, 32'h8, 32'h9, 1'b1);
        check("clr.valid", 64'(valid_o), 64'd1);
        check_all("clr", 32'h9, 3'b010, 1'b1, 1'b0, 2'b00, 3'b000, 12'h000);
        apply(1'b1, 32'h9, 32'h8, 32'h9, 1'b0);
        check_all("postclr", 32'h9, 3'b010, 1'b1, 1'b0, 2'b00, 3'b000, 12'h010);

        // Asynchronous reset while a valid sample is being presented.
        valid_i = 1'b1;
        in_1_i  = 32'h4444;
        in_2_i  = 32'h4444;
        in_3_i  = 32'h3333;
        #2 rst_n = 1'b0;
        #1;
        check("arst.valid", 64'(valid_o), 64'd0);
        check_all("arst", 32'h0, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 32'h4444, 32'h4444, 32'h3333, 1'b0);
        check_all("afterrst", 32'h4444, 3'b100, 1'b1, 1'b0, 2'b00, 3'b000, 12'h100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
